// File: rtl/sd_cmd_engine_if.sv
// Host/phy signal bundle for the SD command engine.
// The engine uses the slave modport. The host/phy environment uses the master modport.
interface sd_cmd_engine_if #(
    parameter int ARG_W   = 32,
    parameter int RESP_W  = 128,
    parameter int FRAME_W = 136,
    parameter int CNT_W   = 16,
    parameter int RETRY_W = 2
);
    // host request side
    logic               new_command;
    logic [5:0]         cmd_index;
    logic [ARG_W-1:0]   cmd_argument;
    logic               timeout_enable;
    logic [CNT_W-1:0]   timeout_limit;
    // phy side
    logic               serial_ready;
    logic               strobe_in;
    logic [FRAME_W-1:0] cmd_in;
    logic               ack_in;
    // engine outputs
    logic               busy;
    logic               setup_done;
    logic [39:0]        cmd_out;
    logic               strobe_out;
    logic               ack_out;
    logic               idle_out;
    logic [RESP_W-1:0]  response;
    logic               command_complete;
    logic               command_index_error;
    logic               command_timeout;
    logic [RETRY_W-1:0] retry_count;

    modport slave (
        input  new_command, cmd_index, cmd_argument, timeout_enable, timeout_limit,
               serial_ready, strobe_in, cmd_in, ack_in,
        output busy, setup_done, cmd_out, strobe_out, ack_out, idle_out, response,
               command_complete, command_index_error, command_timeout, retry_count
    );

    modport master (
        output new_command, cmd_index, cmd_argument, timeout_enable, timeout_limit,
               serial_ready, strobe_in, cmd_in, ack_in,
        input  busy, setup_done, cmd_out, strobe_out, ack_out, idle_out, response,
               command_complete, command_index_error, command_timeout, retry_count
    );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD command-path engine. It builds a command frame, hands it to the phy, waits for
// the response under a programmable timeout, and decodes the response by class.
// It retries on a timeout or an index mismatch. Every output is a flop.
module sd_cmd_engine #(
    parameter int ARG_W           = 32,
    parameter int RESP_W          = 128,
    parameter int FRAME_W         = 136,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT_DEFAULT = 1024,
    parameter int MAX_RETRIES     = 2,
    parameter int RETRY_W         = 2
) (
    input  logic              clock,
    input  logic              reset,
    sd_cmd_engine_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_RESP, S_ACK, S_FINISH
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_LONG, C_R3, C_STOP, C_SHORT
    } rclass_t;

    function automatic rclass_t classify(input logic [5:0] idx);
        case (idx)
            6'd0, 6'd4, 6'd15:  classify = C_NONE;
            6'd2, 6'd9, 6'd10:  classify = C_LONG;
            6'd41:              classify = C_R3;
            6'd12:              classify = C_STOP;
            default:            classify = C_SHORT;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               idx_err_pend_q, idx_err_pend_d;
    logic               busy_q, busy_d;
    logic               setup_done_q, setup_done_d;
    logic [39:0]        cmd_out_q, cmd_out_d;
    logic               strobe_out_q, strobe_out_d;
    logic               ack_out_q, ack_out_d;
    logic               idle_out_q, idle_out_d;
    logic [RESP_W-1:0]  response_q, response_d;
    logic               complete_q, complete_d;
    logic               idx_err_q, idx_err_d;
    logic               timeout_q, timeout_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    rclass_t            rcls;
    logic [CNT_W-1:0]   eff_limit;
    logic               retry_ok;

    // Frame bits outside the decoded fields are intentionally ignored.
    logic unused_frame_bits;
    assign unused_frame_bits = ^{bus.cmd_in[FRAME_W-1:128], bus.cmd_in[47:46], bus.cmd_in[7:0]};

    assign rcls      = classify(idx_q);
    assign eff_limit = (bus.timeout_limit == '0) ? CNT_W'(TIMEOUT_DEFAULT) : bus.timeout_limit;
    assign retry_ok  = (retry_q < RETRY_W'(MAX_RETRIES));

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        idx_err_pend_d = idx_err_pend_q;
        cmd_out_d      = cmd_out_q;
        response_d     = response_q;
        idx_err_d      = idx_err_q;
        timeout_d      = timeout_q;
        retry_d        = retry_q;

        case (state_q)
            S_IDLE: begin
                if (bus.new_command) begin
                    idx_d          = bus.cmd_index;
                    cmd_out_d      = {2'b01, bus.cmd_index, 32'(bus.cmd_argument)};
                    response_d     = '0;
                    idx_err_d      = 1'b0;
                    timeout_d      = 1'b0;
                    retry_d        = '0;
                    idx_err_pend_d = 1'b0;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.serial_ready) begin
                    if (rcls == C_NONE) begin
                        state_d = S_FINISH;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (bus.strobe_in) begin
                    // A mismatched frame leaves the response at zero. The retry decision is made in ACK.
                    response_d     = '0;
                    idx_err_pend_d = 1'b0;
                    case (rcls)
                        C_LONG: response_d[119:0] = bus.cmd_in[127:8];
                        C_R3:   response_d[31:0]  = bus.cmd_in[39:8];
                        C_STOP: begin
                            if (bus.cmd_in[45:40] == idx_q) response_d[127:96] = bus.cmd_in[39:8];
                            else                            idx_err_pend_d     = 1'b1;
                        end
                        default: begin
                            if (bus.cmd_in[45:40] == idx_q) response_d[31:0] = bus.cmd_in[39:8];
                            else                            idx_err_pend_d   = 1'b1;
                        end
                    endcase
                    state_d = S_ACK;
                end else if (bus.timeout_enable && (cnt_q == eff_limit)) begin
                    if (retry_ok) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_SEND;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (bus.ack_in) begin
                    if (idx_err_pend_q) begin
                        if (retry_ok) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_SEND;
                        end else begin
                            idx_err_d = 1'b1;
                            state_d   = S_FINISH;
                        end
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state, so they line up with the state register.
        busy_d       = (state_d != S_IDLE);
        idle_out_d   = (state_d == S_IDLE);
        strobe_out_d = (state_d == S_SEND) || (state_d == S_WAIT_RESP);
        ack_out_d    = (state_d == S_ACK);
        complete_d   = (state_d == S_FINISH);
        setup_done_d = (state_d == S_SEND) && (state_q != S_SEND);
    end

    // State, context and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            idx_err_pend_q <= 1'b0;
            busy_q         <= 1'b0;
            setup_done_q   <= 1'b0;
            cmd_out_q      <= '0;
            strobe_out_q   <= 1'b0;
            ack_out_q      <= 1'b0;
            idle_out_q     <= 1'b1;
            response_q     <= '0;
            complete_q     <= 1'b0;
            idx_err_q      <= 1'b0;
            timeout_q      <= 1'b0;
            retry_q        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            idx_err_pend_q <= idx_err_pend_d;
            busy_q         <= busy_d;
            setup_done_q   <= setup_done_d;
            cmd_out_q      <= cmd_out_d;
            strobe_out_q   <= strobe_out_d;
            ack_out_q      <= ack_out_d;
            idle_out_q     <= idle_out_d;
            response_q     <= response_d;
            complete_q     <= complete_d;
            idx_err_q      <= idx_err_d;
            timeout_q      <= timeout_d;
            retry_q        <= retry_d;
        end
    end

    assign bus.busy                = busy_q;
    assign bus.setup_done          = setup_done_q;
    assign bus.cmd_out             = cmd_out_q;
    assign bus.strobe_out          = strobe_out_q;
    assign bus.ack_out             = ack_out_q;
    assign bus.idle_out            = idle_out_q;
    assign bus.response            = response_q;
    assign bus.command_complete    = complete_q;
    assign bus.command_index_error = idx_err_q;
    assign bus.command_timeout     = timeout_q;
    assign bus.retry_count         = retry_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed self-checking bench for sd_cmd_engine.
module tb_sd_cmd_engine;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   done_at, setups, acks;

    sd_cmd_engine_if bus ();

    sd_cmd_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [135:0] mkframe(input logic [5:0] idx, input logic [31:0] pl);
        mkframe = {8'hC3, {10{8'h96}}, 2'b00, idx, pl, 8'h01};
    endfunction

    // Issues a command, then acts as a simple phy. serial_ready is always high.
    // A response frame goes out 'delay' cycles after each setup_done (never if delay<0).
    // ack_in follows ack_out. The task returns the cycle of command_complete (-1 if max is reached).
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ten,
                           input logic [15:0] lim, input int delay,
                           input logic [135:0] f0, input logic [135:0] f1, input logic [135:0] f2,
                           input int max_cycles,
                           output int d_at, output int n_set, output int n_ack);
        int since;
        since = -1;
        d_at  = -1;
        n_set = 0;
        n_ack = 0;
        bus.cmd_index      = idx;
        bus.cmd_argument   = arg;
        bus.timeout_enable = ten;
        bus.timeout_limit  = lim;
        bus.serial_ready   = 1'b1;
        bus.new_command    = 1'b1;
        for (int n = 1; n <= max_cycles; n++) begin
            tick();
            bus.new_command = 1'b0;
            bus.strobe_in   = 1'b0;
            if (bus.setup_done) begin
                n_set++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (bus.ack_out) n_ack++;
            bus.ack_in = bus.ack_out;
            if (delay >= 0 && since == delay) begin
                bus.strobe_in = 1'b1;
                bus.cmd_in    = (n_set <= 1) ? f0 : (n_set == 2) ? f1 : f2;
            end
            if (bus.command_complete) begin
                d_at = n;
                break;
            end
        end
        bus.serial_ready = 1'b0;
        bus.strobe_in    = 1'b0;
        bus.ack_in       = 1'b0;
    endtask

    initial begin
        bus.new_command    = 1'b0;
        bus.cmd_index      = '0;
        bus.cmd_argument   = '0;
        bus.timeout_enable = 1'b0;
        bus.timeout_limit  = '0;
        bus.serial_ready   = 1'b0;
        bus.strobe_in      = 1'b0;
        bus.cmd_in         = '0;
        bus.ack_in         = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_idle", bus.idle_out, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_strobe", bus.strobe_out, 1'b0);
        chk("rst_cmd_out", bus.cmd_out, 40'h0);
        chk("rst_resp", bus.response, 128'h0);
        reset = 1'b0;
        tick();

        // CMD17 with manual phy timing
        bus.cmd_index      = 6'd17;
        bus.cmd_argument   = 32'h0000_1000;
        bus.timeout_enable = 1'b1;
        bus.timeout_limit  = 16'd0;
        bus.new_command    = 1'b1;
        tick();  // E1: SEND
        chk("c17_strobe_lat", bus.strobe_out, 1'b1);
        chk("c17_setup", bus.setup_done, 1'b1);
        chk("c17_busy", bus.busy, 1'b1);
        chk("c17_idle", bus.idle_out, 1'b0);
        chk("c17_cmd_out", bus.cmd_out, 40'h51_0000_1000);
        bus.cmd_index    = 6'd5;         // ignored while busy
        bus.cmd_argument = 32'hFFFF_FFFF;
        tick();  // E2
        chk("c17_setup_pulse", bus.setup_done, 1'b0);
        chk("c17_cmd_out_hold", bus.cmd_out, 40'h51_0000_1000);
        bus.new_command  = 1'b0;
        bus.serial_ready = 1'b1;
        tick();  // E3: WAIT_RESP
        bus.serial_ready = 1'b0;
        repeat (6) tick();  // E9
        chk("c17_wait_strobe", bus.strobe_out, 1'b1);
        chk("c17_wait_noack", bus.ack_out, 1'b0);
        bus.strobe_in = 1'b1;
        bus.cmd_in    = mkframe(6'd17, 32'h0000_0900);
        tick();  // E10: ACK
        bus.strobe_in = 1'b0;
        chk("c17_ack_out", bus.ack_out, 1'b1);
        chk("c17_strobe_drop", bus.strobe_out, 1'b0);
        chk("c17_resp", bus.response, 128'h900);
        tick();  // E11: still ACK
        chk("c17_ack_hold", bus.ack_out, 1'b1);
        chk("c17_no_early_cc", bus.command_complete, 1'b0);
        bus.ack_in = 1'b1;
        tick();  // E12: FINISH
        bus.ack_in = 1'b0;
        chk("c17_cc", bus.command_complete, 1'b1);
        chk("c17_ack_drop", bus.ack_out, 1'b0);
        chk("c17_idxerr", bus.command_index_error, 1'b0);
        chk("c17_tout", bus.command_timeout, 1'b0);
        chk("c17_retry", bus.retry_count, 2'd0);
        tick();  // E13: IDLE
        chk("c17_cc_pulse", bus.command_complete, 1'b0);
        chk("c17_busy_end", bus.busy, 1'b0);
        chk("c17_idle_end", bus.idle_out, 1'b1);
        chk("c17_resp_hold", bus.response, 128'h900);
        tick();

        // CMD2 long response
        run_cmd(6'd2, 32'h0, 1'b0, 16'd0, 2, {8'h3C, {15{8'hA5}}, 8'h11}, '0, '0, 40,
                done_at, setups, acks);
        chk("c2_done_at", done_at, 5);
        chk("c2_resp", bus.response, {8'h00, {15{8'hA5}}});
        chk("c2_idxerr", bus.command_index_error, 1'b0);
        tick();

        // CMD0: no response phase
        run_cmd(6'd0, 32'h1234_5678, 1'b1, 16'd5, -1, '0, '0, '0, 40, done_at, setups, acks);
        chk("c0_done_at", done_at, 2);
        chk("c0_acks", acks, 0);
        chk("c0_strobe", bus.strobe_out, 1'b0);
        chk("c0_cmd_out", bus.cmd_out, 40'h40_1234_5678);
        chk("c0_resp", bus.response, 128'h0);
        tick();

        // CMD12 stop: response lands in the top word
        run_cmd(6'd12, 32'h0, 1'b0, 16'd0, 2, mkframe(6'd12, 32'hCAFE_F00D), '0, '0, 40,
                done_at, setups, acks);
        chk("c12_done_at", done_at, 5);
        chk("c12_resp", bus.response, {32'hCAFE_F00D, 96'h0});
        tick();

        // CMD41 R3: the index field is not checked
        run_cmd(6'd41, 32'h0, 1'b0, 16'd0, 2, mkframe(6'h3F, 32'h80FF_8000), '0, '0, 40,
                done_at, setups, acks);
        chk("c41_resp", bus.response, 128'h80FF_8000);
        chk("c41_idxerr", bus.command_index_error, 1'b0);
        chk("c41_retry", bus.retry_count, 2'd0);
        tick();

        // CMD8 timeout: three attempts of 1 SEND + 6 WAIT cycles each
        run_cmd(6'd8, 32'h1AA, 1'b1, 16'd5, -1, '0, '0, '0, 60, done_at, setups, acks);
        chk("c8t_done_at", done_at, 22);
        chk("c8t_setups", setups, 3);
        chk("c8t_acks", acks, 0);
        chk("c8t_retry", bus.retry_count, 2'd2);
        chk("c8t_tout", bus.command_timeout, 1'b1);
        chk("c8t_idxerr", bus.command_index_error, 1'b0);
        tick();
        chk("c8t_tout_sticky", bus.command_timeout, 1'b1);
        chk("c8t_idle", bus.idle_out, 1'b1);
        tick();

        // CMD8: strobe on the limit cycle wins over the timeout
        run_cmd(6'd8, 32'h1AA, 1'b1, 16'd5, 6, mkframe(6'd8, 32'h0000_01AA), '0, '0, 60,
                done_at, setups, acks);
        chk("c8l_done_at", done_at, 9);
        chk("c8l_setups", setups, 1);
        chk("c8l_tout", bus.command_timeout, 1'b0);
        chk("c8l_retry", bus.retry_count, 2'd0);
        chk("c8l_resp", bus.response, 128'h1AA);
        tick();

        // CMD13: wrong index on every attempt
        run_cmd(6'd13, 32'h0, 1'b0, 16'd0, 2, mkframe(6'd12, 32'h11), mkframe(6'd12, 32'h22),
                mkframe(6'd12, 32'h33), 60, done_at, setups, acks);
        chk("c13e_done_at", done_at, 13);
        chk("c13e_setups", setups, 3);
        chk("c13e_acks", acks, 3);
        chk("c13e_idxerr", bus.command_index_error, 1'b1);
        chk("c13e_retry", bus.retry_count, 2'd2);
        chk("c13e_tout", bus.command_timeout, 1'b0);
        tick();

        // CMD13: correct index on the second attempt
        run_cmd(6'd13, 32'h0, 1'b0, 16'd0, 2, mkframe(6'd12, 32'h11), mkframe(6'd13, 32'h0000_0B00),
                '0, 60, done_at, setups, acks);
        chk("c13r_done_at", done_at, 9);
        chk("c13r_setups", setups, 2);
        chk("c13r_idxerr", bus.command_index_error, 1'b0);
        chk("c13r_retry", bus.retry_count, 2'd1);
        chk("c13r_resp", bus.response, 128'hB00);
        tick();

        // Reset in WAIT_RESP during the second attempt
        run_cmd(6'd8, 32'h1AA, 1'b1, 16'd5, -1, '0, '0, '0, 10, done_at, setups, acks);
        chk("rw_not_done", done_at, -1);
        chk("rw_retry_pre", bus.retry_count, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_idle", bus.idle_out, 1'b1);
        chk("rw_busy", bus.busy, 1'b0);
        chk("rw_strobe", bus.strobe_out, 1'b0);
        chk("rw_retry", bus.retry_count, 2'd0);
        chk("rw_flags", {bus.command_timeout, bus.command_index_error, bus.command_complete,
                         bus.setup_done, bus.ack_out}, 5'b0);
        chk("rw_cmd_out", bus.cmd_out, 40'h0);
        tick();
        chk("rw_stays_idle", bus.idle_out, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Parametrised next-generation SD command-path controller between the host register interface and the CMD-line physical/serialiser layer.
- Builds a 48-bit-class command frame (start/transmission bits, index, argument) and hands it to the phy.
- Waits for the response with an internal programmable timeout, decodes it per response class and checks the index.
- Retries automatically on timeout or index mismatch up to a parameter limit.
- All outputs are registered.

Parameters:
- ARG_W, 32: command argument width.
- RESP_W, 128: host response register width; must be ≥128.
- FRAME_W, 136: raw response frame width from phy.
- CNT_W, 16: timeout counter width.
- TIMEOUT_DEFAULT, 1024: response wait limit in cycles, used when timeout_limit==0.
- MAX_RETRIES, 2: reissues allowed after the first attempt.
- RETRY_W, 2: width of retry_count; must hold MAX_RETRIES.

Ports:
- clock in 1: single clock.
- reset in 1: synchronous, active-high.
- new_command in 1: host request, sampled only in IDLE.
- cmd_index in 6: command index, captured at request.
- cmd_argument in ARG_W: argument, captured at request.
- timeout_enable in 1: 1 = timeout active; 0 = wait indefinitely.
- timeout_limit in CNT_W: response wait cycles; 0 selects TIMEOUT_DEFAULT.
- serial_ready in 1: phy accepted/transmitted cmd_out.
- strobe_in in 1: phy response frame valid.
- cmd_in in FRAME_W: raw response frame.
- ack_in in 1: phy acknowledges ack_out.
- busy out 1: high from request capture until return to IDLE.
- setup_done out 1: one-cycle pulse per frame presented (each attempt).
- cmd_out out 40: {2'b01, index, argument[31:0]}.
- strobe_out out 1: frame valid to phy.
- ack_out out 1: response consumed.
- idle_out out 1: high only in IDLE.
- response out RESP_W: decoded response.
- command_complete out 1: one-cycle pulse at end of command, success or error.
- command_index_error out 1: sticky until next request.
- command_timeout out 1: sticky until next request.
- retry_count out RETRY_W: attempts minus one for the current/last command.

Behaviour:
- Reset (synchronous, any state, mid-command included): state=IDLE. All outputs 0 except idle_out=1. Counters cleared, captured index/argument cleared.
- States and transitions:
  - IDLE: on new_command → capture index/arg, clear response/flags/retry_count, busy=1 → SEND.
  - SEND: strobe_out=1, cmd_out driven; setup_done pulses on the first SEND cycle. On serial_ready: if class NONE → FINISH; else clear counter → WAIT_RESP.
  - WAIT_RESP: strobe_out=1; counter increments each cycle without strobe_in.
    - strobe_in → decode → ACK.
    - With timeout_enable=1 and counter==limit and no strobe_in → timeout event.
    - strobe_in on the limit cycle wins; no timeout.
  - ACK: ack_out=1 until ack_in sampled high → FINISH, or → SEND when a retry is pending.
  - FINISH: command_complete=1 for one cycle, busy=0 next cycle → IDLE.
- Response classes, from the captured index:
  - NONE = 0, 4, 15.
  - LONG = 2, 9, 10: response[119:0]=cmd_in[127:8], upper bits 0, no index check.
  - R3 = 41: response[31:0]=cmd_in[39:8], no index check.
  - STOP = 12: response[127:96]=cmd_in[39:8].
  - SHORT = all others: response[31:0]=cmd_in[39:8].
  - STOP and SHORT check cmd_in[45:40]==index; mismatch sets a pending index error.
- Retry:
  - Trigger: timeout event, or index error seen in ACK.
  - If retry_count<MAX_RETRIES: increment retry_count, keep response=0, → SEND. A timeout goes directly to SEND; no ack_out is issued.
  - Otherwise set command_timeout or command_index_error → FINISH.
  - A successful later attempt clears the pending error.
- new_command outside IDLE is ignored. cmd_index/cmd_argument changes after capture have no effect.
- Latency: request to strobe_out = 1 cycle. ack_in to command_complete = 1 cycle.
- Counter saturates at its maximum and never wraps.

Test Plan:
- CMD17, arg 0x0000_1000; serial_ready at cycle 3; strobe_in at cycle 10 with cmd_in[45:40]=17, cmd_in[39:8]=0x0000_0900; ack_in → response[31:0]=0x0000_0900, no error flags, command_complete pulses once, retry_count=0.
- CMD2 long; cmd_in[127:8]=0xA5…A5 → response[119:0] matches, response[127:120]=0.
- CMD0 → completes after serial_ready with no WAIT_RESP; strobe_out drops; ack_out never asserted.
- CMD8, timeout_enable=1, timeout_limit=5, no strobe_in → three SEND attempts, retry_count=2, command_timeout=1, complete pulse. Repeat with strobe_in exactly on the limit cycle → no timeout.
- CMD13 with returned index 12 on every attempt → command_index_error=1 after 3 attempts. Same with index 13 on the 2nd attempt → no error, retry_count=1.
- Reset asserted in WAIT_RESP → next cycle idle_out=1, busy=0, all flags 0. new_command during busy → ignored.
